instr_fetch_unit: RTL

Fetch stage of the multicycle RISC-V core: holds the PC, issues one instruction-memory read per fetch command over a request/response handshake, and latches the returned word into the instruction register. The latched instruction and its opcode field drive the immediate generator and the control decoder. The PC of the fetched instruction is kept separately for branch-target arithmetic.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction-memory read request/response handshake
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle core fetch stage: PC, imem read, instruction register
// Optional memory-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_go,
    input  logic                       pc_load,
    input  logic [31:0]                pc_next,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                ir,
    output logic [6:0]                 op,
    output logic                       ir_valid,
    output logic [31:0]                pc,
    output logic [31:0]                old_pc,
    output logic                       fetch_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // A zero limit would fault every fetch before memory could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] old_pc_q, old_pc_d;
    logic [31:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] eff_pc;
    logic        capture;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        old_pc_d    = old_pc_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        fetch_err_d = fetch_err_q;
        capture     = 1'b0;
        eff_pc      = pc_load ? pc_next : pc_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (pc_load) begin
                    pc_d = pc_next;
                end
                if (fetch_go) begin
                    if (eff_pc[1:0] == 2'b00) begin
                        imem_addr_d = eff_pc;
                        imem_req_d  = 1'b1;
                        ir_valid_d  = 1'b0;
                        state_d     = REQ;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        fetch_err_d = 1'b1;
                        state_d     = ERR;
                    end
                end
            end
            REQ: begin
                if (imem.imem_ack) begin
                    imem_req_d = 1'b0;
                    if (imem.imem_rvalid) begin
                        capture = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    capture = 1'b1;
                end
            end
            ERR: begin
                if (pc_load && (pc_next[1:0] == 2'b00)) begin
                    pc_d        = pc_next;
                    fetch_err_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The held request address is the fetched instruction's own PC.
        if (capture) begin
            ir_d       = imem.imem_rdata;
            old_pc_d   = imem_addr_q;
            pc_d       = imem_addr_q + 32'd4;
            ir_valid_d = 1'b1;
            state_d    = IDLE;
        end

`ifdef FETCH_TIMEOUT_EN
        if ((state_q == REQ) || (state_q == WAIT)) begin
            cnt_d = cnt_q + 1'b1;
            if (!capture && (cnt_q == LAST_CNT)) begin
                imem_req_d  = 1'b0;
                fetch_err_d = 1'b1;
                state_d     = ERR;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            old_pc_q    <= RESET_PC;
            ir_q        <= NOP;
            ir_valid_q  <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            fetch_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            old_pc_q    <= old_pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            fetch_err_q <= fetch_err_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = imem_addr_q;
    assign ir             = ir_q;
    assign op             = ir_q[6:0];
    assign ir_valid       = ir_valid_q;
    assign pc             = pc_q;
    assign old_pc         = old_pc_q;
    assign fetch_err      = fetch_err_q;

endmodule
